// File: rtl/shuffle_stream_pkg.sv
// ============================================================================
// shuffle_stream_pkg : shared types and helpers for the streaming gather shuffle
// Rev 1.0
// ============================================================================
`default_nettype none

package shuffle_stream_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int DEF_IN_ELEMS = 16;
    localparam int DEF_FOLD     = 4;
    localparam int FRAME_ELEMS  = DEF_IN_ELEMS * DEF_FOLD;

    // Upper bound on the flattened gather table width accepted by perm_idx
    localparam int PERM_MAX_W = 8192;

    function automatic int perm_idx(input logic [PERM_MAX_W-1:0] perm,
                                    input int k, input int idx_w);
        logic [PERM_MAX_W-1:0] s;
        s = perm >> (k * idx_w);
        return int'(s[31:0]) & ((1 << idx_w) - 1);
    endfunction

    function automatic int cnt_width(input int fold, input int out_beats);
        return $clog2(((fold > out_beats) ? fold : out_beats) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shuffle_gather.sv
// ============================================================================
// shuffle_gather : combinational gather of one output beat from a flat frame
// Rev 1.0
// ============================================================================
`default_nettype none

module shuffle_gather
    import shuffle_stream_pkg::*;
#(
    parameter int ELEM_W    = 2,
    parameter int IN_ELEMS  = 16,
    parameter int FOLD      = 4,
    parameter int OUT_ELEMS = 16,
    parameter int OUT_BEATS = 4,
    parameter int IDX_W     = $clog2(IN_ELEMS * FOLD),
    parameter int CNT_W     = 3,
    parameter logic [OUT_ELEMS*OUT_BEATS*IDX_W-1:0] PERM = '0
) (
    input  logic [FOLD*IN_ELEMS*ELEM_W-1:0] frame,
    input  logic [CNT_W-1:0]                sel,
    output logic [OUT_ELEMS*ELEM_W-1:0]     beat
);

    localparam int c_frame_n = IN_ELEMS * FOLD;
    localparam int c_obeat_w = OUT_ELEMS * ELEM_W;

    logic [c_obeat_w-1:0] w_cand [OUT_BEATS];

    if (OUT_ELEMS * OUT_BEATS * IDX_W > PERM_MAX_W) begin : g_perm_too_wide
        $error("shuffle_gather: PERM wider than PERM_MAX_W");
    end

    // Every output beat is a fixed wiring of the frame; only the beat select is muxed
    for (genvar j = 0; j < OUT_BEATS; j++) begin : g_beat
        for (genvar e = 0; e < OUT_ELEMS; e++) begin : g_elem
            localparam int c_src = perm_idx(PERM_MAX_W'(PERM), j * OUT_ELEMS + e, IDX_W);
            if (c_src >= c_frame_n) begin : g_bad_idx
                $error("shuffle_gather: PERM entry out of frame range");
            end else begin : g_ok
                assign w_cand[j][e*ELEM_W +: ELEM_W] = frame[c_src*ELEM_W +: ELEM_W];
            end
        end
    end

    always_comb begin
        beat = '0;
        for (int j = 0; j < OUT_BEATS; j++) begin
            if (sel == CNT_W'(j)) beat = w_cand[j];
        end
    end

endmodule

`default_nettype wire

// File: rtl/shuffle_stream.sv
// ============================================================================
// shuffle_stream : AXI-Stream frame buffer with compile-time cross-beat gather
// Optional macro SHUFFLE_STREAM_DBUF_EN selects a double-banked frame buffer.
// Rev 1.0
// ============================================================================
`default_nettype none

module shuffle_stream
    import shuffle_stream_pkg::*;
#(
    parameter int ELEM_W    = 2,
    parameter int IN_ELEMS  = 16,
    parameter int FOLD      = 4,
    parameter int OUT_ELEMS = 16,
    parameter int OUT_BEATS = 4,
    parameter int IDX_W     = $clog2(IN_ELEMS * FOLD),
    parameter logic [OUT_ELEMS*OUT_BEATS*IDX_W-1:0] PERM = '0
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [IN_ELEMS*ELEM_W-1:0]    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [OUT_ELEMS*ELEM_W-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
);

    localparam int c_beat_w  = IN_ELEMS * ELEM_W;
    localparam int c_obeat_w = OUT_ELEMS * ELEM_W;
    localparam int c_frame_w = FOLD * c_beat_w;
    localparam int CNT_W     = cnt_width(FOLD, OUT_BEATS);
    localparam logic [CNT_W-1:0] c_in_last  = CNT_W'(FOLD - 1);
    localparam logic [CNT_W-1:0] c_out_last = CNT_W'(OUT_BEATS - 1);
    localparam logic [CNT_W-1:0] c_out_pen  = CNT_W'(OUT_BEATS - 2);

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_in_cnt, r_out_cnt, w_gsel;
    logic [c_obeat_w-1:0] r_tdata, w_gbeat;
    logic                 r_tvalid, r_tlast;
    logic                 w_in_fire, w_out_fire, w_in_last, w_out_last, w_handoff;
    logic [c_frame_w-1:0] w_fill_cur, w_drain_cur, w_fill_frame, w_gframe;

    assign s_axis_tready = (r_state == FILL);
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;

    assign w_in_fire  = s_axis_tvalid && s_axis_tready;
    assign w_out_fire = r_tvalid && m_axis_tready;
    assign w_in_last  = w_in_fire && (r_in_cnt == c_in_last);
    assign w_out_last = w_out_fire && (r_out_cnt == c_out_last);

`ifdef SHUFFLE_STREAM_DBUF_EN
    logic [c_frame_w-1:0] r_bank0, r_bank1;
    logic                 r_wb;
    logic                 w_can_take;

    // r_wb names the bank being filled; the other bank is the one draining
    assign w_fill_cur  = r_wb ? r_bank1 : r_bank0;
    assign w_drain_cur = r_wb ? r_bank0 : r_bank1;
    assign w_can_take  = !r_tvalid || w_out_last;

    always_ff @(posedge ap_clk) begin
        if (w_in_fire) begin
            if (r_wb) r_bank1 <= w_fill_frame;
            else      r_bank0 <= w_fill_frame;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst)         r_wb <= 1'b0;
        else if (w_handoff) r_wb <= ~r_wb;
    end

    // DRAIN here means a full bank is parked waiting for the drain side
    always_comb begin
        w_state_nxt = r_state;
        w_handoff   = (w_in_last || (r_state == DRAIN)) && w_can_take;
        case (r_state)
            FILL:    if (w_in_last && !w_can_take) w_state_nxt = DRAIN;
            DRAIN:   if (w_can_take)               w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end
`else
    logic [c_frame_w-1:0] r_bank0;

    assign w_fill_cur  = r_bank0;
    assign w_drain_cur = r_bank0;

    always_ff @(posedge ap_clk) begin
        if (w_in_fire) r_bank0 <= w_fill_frame;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_handoff   = w_in_last;
        case (r_state)
            FILL:    if (w_in_last)  w_state_nxt = DRAIN;
            DRAIN:   if (w_out_last) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end
`endif

    // The final fill beat is merged in so the first gather sees the complete frame
    always_comb begin
        w_fill_frame = w_fill_cur;
        if (w_in_fire) w_fill_frame[r_in_cnt*c_beat_w +: c_beat_w] = s_axis_tdata;
        w_gframe = w_handoff ? w_fill_frame : w_drain_cur;
        w_gsel   = w_handoff ? '0 : r_out_cnt + 1'b1;
    end

    shuffle_gather #(
        .ELEM_W    (ELEM_W),
        .IN_ELEMS  (IN_ELEMS),
        .FOLD      (FOLD),
        .OUT_ELEMS (OUT_ELEMS),
        .OUT_BEATS (OUT_BEATS),
        .IDX_W     (IDX_W),
        .CNT_W     (CNT_W),
        .PERM      (PERM)
    ) u_gather (
        .frame (w_gframe),
        .sel   (w_gsel),
        .beat  (w_gbeat)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state   <= FILL;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fire) r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
            if (w_handoff) begin
                r_out_cnt <= '0;
                r_tdata   <= w_gbeat;
                r_tvalid  <= 1'b1;
                r_tlast   <= (OUT_BEATS == 1);
            end else if (w_out_fire) begin
                if (w_out_last) begin
                    r_out_cnt <= '0;
                    r_tvalid  <= 1'b0;
                    r_tlast   <= 1'b0;
                end else begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                    r_tdata   <= w_gbeat;
                    r_tlast   <= (r_out_cnt == c_out_pen);
                end
            end
        end
    end

endmodule

`default_nettype wire
